// File: rtl/vram_rdarb_pkg.sv
// vram_rdarb shared types: owner ids, AR FSM states, defaults.
// Imported by the interface, order FIFO and arbiter top.
package vram_rdarb_pkg;
  localparam int DEF_ORDDEPTH = 8;
  localparam int DEF_DATAW = 64;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } own_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } ar_st_e;
endpackage

// File: rtl/vram_rdarb_if.sv
// Read-only AXI-style AR/R bundle between a requester and VRAM.
// master: drives AR + RREADY; slave: drives ARREADY + R.
interface vram_rdarb_if
  import vram_rdarb_pkg::*;
#(
  parameter int DATAW = DEF_DATAW
);
  logic [31:0]      ARADDR;
  logic [7:0]       ARLEN;
  logic             ARVALID;
  logic             ARREADY;
  logic [DATAW-1:0] RDATA;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY;

  modport master (
    output ARADDR, ARLEN, ARVALID, RREADY,
    input  ARREADY, RDATA, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARVALID, RREADY,
    output ARREADY, RDATA, RLAST, RVALID
  );
endinterface

// File: rtl/vram_rdarb_ordfifo.sv
// Burst order FIFO: one owner id per accepted AR, popped on RLAST.
// Ports: clk, rst_n, push/din, pop, head (oldest owner), count.
module vram_rdarb_ordfifo
  import vram_rdarb_pkg::*;
#(
  parameter int DEPTH = DEF_ORDDEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  own_e       din,
  input  logic       pop,
  output own_e       head,
  output logic [4:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != 5'd0);
    do_push = push && (cnt_q != 5'(DEPTH));
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = din;
      wp_d        = wp_q + 1'b1;
    end
    if (do_pop) begin
      rp_d = rp_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = own_e'(mem_q[rp_q]);
  assign count = cnt_q;
endmodule

// File: rtl/vram_rdarb.sv
// Two-requester VRAM read arbiter: AR grant FSM + in-order R routing.
// Ports: ACLK, ARESETN, M0/M1 (requesters), S (VRAM), DISP_URGENT, OUTSTANDING.
module vram_rdarb
  import vram_rdarb_pkg::*;
#(
  parameter int ORDDEPTH = DEF_ORDDEPTH,
  parameter int DATAW    = DEF_DATAW
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  vram_rdarb_if.slave       M0,
  vram_rdarb_if.slave       M1,
  vram_rdarb_if.master      S,
  input  logic              DISP_URGENT,
  output logic [4:0]        OUTSTANDING
);
  ar_st_e      st_q, st_d;
  own_e        last_q, last_d;
  own_e        own_q, own_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  own_e        win, head;
  logic        grant, ar_hs, r_pop, fifo_ne;
  logic        urg_m0, tie, only_m1;
  logic [4:0]  count;
  logic [DATAW-1:0] rdata;

  always_comb begin
    urg_m0  = DISP_URGENT && M0.ARVALID;
    tie     = !DISP_URGENT && M0.ARVALID && M1.ARVALID;
    only_m1 = M1.ARVALID && !M0.ARVALID;
    unique case (1'b1)
      urg_m0:  win = OWN_M0;
      tie:     win = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
      only_m1: win = OWN_M1;
      default: win = OWN_M0;
    endcase
  end

  always_comb begin
    grant = (st_q == ST_IDLE)
         && (M0.ARVALID || M1.ARVALID)
         && (count < 5'(ORDDEPTH));
    ar_hs = (st_q == ST_ISSUE) && S.ARREADY;
    M0.ARREADY = grant && (win == OWN_M0);
    M1.ARREADY = grant && (win == OWN_M1);
  end

  always_comb begin
    st_d   = st_q;
    last_d = last_q;
    own_d  = own_q;
    addr_d = addr_q;
    len_d  = len_q;
    unique case (st_q)
      ST_IDLE: begin
        if (grant) begin
          st_d   = ST_ISSUE;
          own_d  = win;
          addr_d = (win == OWN_M1) ? M1.ARADDR : M0.ARADDR;
          len_d  = (win == OWN_M1) ? M1.ARLEN : M0.ARLEN;
        end
      end
      ST_ISSUE: begin
        if (ar_hs) begin
          st_d   = ST_IDLE;
          last_d = own_q;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      st_q   <= ST_IDLE;
      last_q <= OWN_M1;
      own_q  <= OWN_M0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
      own_q  <= own_d;
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  assign S.ARVALID = (st_q == ST_ISSUE);
  assign S.ARADDR  = addr_q;
  assign S.ARLEN   = len_q;

  vram_rdarb_ordfifo #(
    .DEPTH (ORDDEPTH)
  ) u_ord (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (ar_hs),
    .din   (own_q),
    .pop   (r_pop),
    .head  (head),
    .count (count)
  );

  assign fifo_ne = (count != 5'd0);
  assign rdata   = S.RDATA;
  assign M0.RDATA = rdata;
  assign M1.RDATA = rdata;

  // Only the oldest outstanding burst's owner sees the R channel.
  always_comb begin
    M0.RVALID = fifo_ne && (head == OWN_M0) && S.RVALID;
    M1.RVALID = fifo_ne && (head == OWN_M1) && S.RVALID;
    M0.RLAST  = fifo_ne && (head == OWN_M0) && S.RLAST;
    M1.RLAST  = fifo_ne && (head == OWN_M1) && S.RLAST;
    S.RREADY  = fifo_ne
             && ((head == OWN_M1) ? M1.RREADY : M0.RREADY);
  end

  assign r_pop       = S.RVALID && S.RREADY && S.RLAST;
  assign OUTSTANDING = count;
endmodule

// File: tb/tb_vram_rdarb.sv
// Scoreboard bench for vram_rdarb: requester/VRAM models, grant log,
// per-requester expected-beat queues.
module tb_vram_rdarb;
  import vram_rdarb_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  l;
  } burst_t;

  logic clk;
  logic rst_n;
  logic urgent;
  logic [4:0] outst;

  vram_rdarb_if #(.DATAW(64)) m0_if ();
  vram_rdarb_if #(.DATAW(64)) m1_if ();
  vram_rdarb_if #(.DATAW(64)) s_if ();

  vram_rdarb #(
    .ORDDEPTH (8),
    .DATAW    (64)
  ) dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .M0          (m0_if),
    .M1          (m1_if),
    .S           (s_if),
    .DISP_URGENT (urgent),
    .OUTSTANDING (outst)
  );

  logic        rv [2];
  logic [31:0] ra [2];
  logic [7:0]  rl [2];
  logic        rr [2];
  logic        ary [2];
  logic        rvld [2];
  logic        rlst [2];
  logic [63:0] rdat [2];

  assign m0_if.ARVALID = rv[0];
  assign m0_if.ARADDR  = ra[0];
  assign m0_if.ARLEN   = rl[0];
  assign m0_if.RREADY  = rr[0];
  assign m1_if.ARVALID = rv[1];
  assign m1_if.ARADDR  = ra[1];
  assign m1_if.ARLEN   = rl[1];
  assign m1_if.RREADY  = rr[1];
  assign ary[0]  = m0_if.ARREADY;
  assign ary[1]  = m1_if.ARREADY;
  assign rvld[0] = m0_if.RVALID;
  assign rvld[1] = m1_if.RVALID;
  assign rlst[0] = m0_if.RLAST;
  assign rlst[1] = m1_if.RLAST;
  assign rdat[0] = m0_if.RDATA;
  assign rdat[1] = m1_if.RDATA;

  burst_t      rq [2][$];
  logic [64:0] exq [2][$];
  burst_t      sq [$];
  int          glog [$];
  int          gcyc [$];
  int          blog [$];
  int          nbeat [2];
  logic        req_en [2];
  logic        ar_en, r_en, thr;
  int          cyc;
  int          nchk, nfail;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic req_proc(input int k);
    bit hs;
    burst_t b;
    rv[k] = 0;
    ra[k] = '0;
    rl[k] = '0;
    rr[k] = 1;
    forever begin
      @(negedge clk);
      hs = rv[k] && ary[k] && rst_n;
      @(posedge clk);
      #1;
      if (hs && rst_n && rq[k].size() > 0) begin
        b = rq[k].pop_front();
        for (int i = 0; i <= int'(b.l); i++)
          exq[k].push_back({(i == int'(b.l)), b.a, 32'(i)});
      end
      rr[k] = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rst_n && req_en[k] && rq[k].size() > 0) begin
        rv[k] = 1;
        ra[k] = rq[k][0].a;
        rl[k] = rq[k][0].l;
      end else begin
        rv[k] = 0;
      end
    end
  endtask

  initial req_proc(0);
  initial req_proc(1);

  // VRAM model: returns bursts in AR order, beat = {addr, index}.
  initial begin
    bit ar_hs, r_hs;
    logic [31:0] aa;
    logic [7:0]  al;
    int sbeat;
    sbeat = 0;
    s_if.ARREADY = 0;
    s_if.RVALID  = 0;
    s_if.RDATA   = '0;
    s_if.RLAST   = 0;
    forever begin
      @(negedge clk);
      ar_hs = s_if.ARVALID && s_if.ARREADY;
      r_hs  = s_if.RVALID && s_if.RREADY;
      aa = s_if.ARADDR;
      al = s_if.ARLEN;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sq.delete();
        sbeat = 0;
      end else begin
        if (r_hs && sq.size() > 0) begin
          if (sbeat == int'(sq[0].l)) begin
            void'(sq.pop_front());
            sbeat = 0;
          end else begin
            sbeat++;
          end
        end
        if (ar_hs) sq.push_back('{aa, al});
      end
      s_if.ARREADY = ar_en;
      if (rst_n && r_en && sq.size() > 0) begin
        s_if.RVALID = 1;
        s_if.RDATA  = {sq[0].a, 32'(sbeat)};
        s_if.RLAST  = (sbeat == int'(sq[0].l));
      end else begin
        s_if.RVALID = 0;
        s_if.RLAST  = 0;
      end
    end
  end

  // Monitor: grant log, AR latency, R beat scoreboard.
  initial begin
    bit pend;
    logic [31:0] paddr;
    logic [7:0]  plen;
    logic [64:0] e;
    pend = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("ar_valid_lat", s_if.ARVALID, 1);
          chk("ar_addr", s_if.ARADDR, paddr);
          chk("ar_len", s_if.ARLEN, plen);
          pend = 0;
        end
        for (int k = 0; k < 2; k++) begin
          if (rv[k] && ary[k]) begin
            glog.push_back(k);
            gcyc.push_back(cyc);
            pend  = 1;
            paddr = ra[k];
            plen  = rl[k];
          end
          if (rvld[k] && rr[k]) begin
            if (exq[k].size() == 0) begin
              chk($sformatf("beat_unexp_m%0d", k), rvld[k], 0);
            end else begin
              e = exq[k].pop_front();
              chk($sformatf("rdata_m%0d", k), rdat[k], e[63:0]);
              chk($sformatf("rlast_m%0d", k), rlst[k], e[64]);
              nbeat[k]++;
              if (e[64]) blog.push_back(k);
            end
          end
        end
        if (rvld[0] && rvld[1]) chk("rvalid_both", rvld[1], 0);
      end
    end
  end

  task automatic do_reset();
    rst_n = 0;
    urgent = 0;
    req_en[0] = 0;
    req_en[1] = 0;
    for (int k = 0; k < 2; k++) begin
      rq[k].delete();
      exq[k].delete();
      nbeat[k] = 0;
    end
    glog.delete();
    gcyc.delete();
    blog.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 &&
         (outst != 0 || exq[0].size() + exq[1].size() != 0 ||
          rq[0].size() + rq[1].size() != 0); i++)
      step();
    chk({tag, "_outst0"}, outst, 0);
    chk({tag, "_exq_empty"}, exq[0].size() + exq[1].size(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nchk = 0;
    nfail = 0;
    rst_n = 0;
    urgent = 0;
    ar_en = 0;
    r_en = 0;
    thr = 0;
    req_en[0] = 0;
    req_en[1] = 0;
    repeat (2) step();
    chk("rst_outst", outst, 0);
    chk("rst_arvalid", s_if.ARVALID, 0);
    chk("rst_araddr", s_if.ARADDR, 0);
    chk("rst_arlen", s_if.ARLEN, 0);
    chk("rst_rready", s_if.RREADY, 0);

    // single M0 burst of 64 beats
    do_reset();
    ar_en = 1;
    r_en = 1;
    rq[0].push_back('{32'h2000_0000, 8'd63});
    req_en[0] = 1;
    for (int i = 0; i < 400 && nbeat[0] < 64; i++) step();
    chk("t1_m0_beats", nbeat[0], 64);
    chk("t1_m1_beats", nbeat[1], 0);
    chk("t1_grants", glog.size(), 1);
    chk("t1_owner", glog[0], 0);
    drain("t1");

    // fair alternation with R backpressure
    do_reset();
    thr = 1;
    for (int i = 0; i < 4; i++) begin
      rq[0].push_back('{32'h0001_0000 + 32'(i * 'h100), 8'd3});
      rq[1].push_back('{32'h0002_0000 + 32'(i * 'h100), 8'd3});
    end
    req_en[0] = 1;
    req_en[1] = 1;
    drain("t2");
    thr = 0;
    chk("t2_grants", glog.size(), 8);
    chk("t2_bursts", blog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_gnt%0d", i), glog[i], i % 2);
      chk($sformatf("t2_ord%0d", i), blog[i], i % 2);
    end

    // display urgency
    do_reset();
    urgent = 1;
    for (int i = 0; i < 6; i++)
      rq[0].push_back('{32'h0003_0000 + 32'(i * 'h40), 8'd1});
    for (int i = 0; i < 2; i++)
      rq[1].push_back('{32'h0004_0000 + 32'(i * 'h40), 8'd1});
    req_en[0] = 1;
    req_en[1] = 1;
    for (int i = 0; i < 100 && glog.size() < 4; i++) step();
    @(posedge clk);
    #1;
    urgent = 0;
    drain("t3");
    chk("t3_grants", glog.size(), 8);
    begin
      int t3_exp [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
      for (int i = 0; i < 8; i++)
        chk($sformatf("t3_gnt%0d", i), glog[i], t3_exp[i]);
    end
    chk("t3_m1_gap", gcyc[4] - gcyc[3], 2);

    // order FIFO full
    do_reset();
    r_en = 0;
    for (int i = 0; i < 5; i++)
      rq[0].push_back('{32'h0005_0000 + 32'(i * 'h20), 8'd1});
    for (int i = 0; i < 4; i++)
      rq[1].push_back('{32'h0006_0000 + 32'(i * 'h20), 8'd1});
    req_en[0] = 1;
    req_en[1] = 1;
    for (int i = 0; i < 100 && outst != 5'd8; i++) step();
    repeat (6) step();
    chk("t4_full", outst, 8);
    chk("t4_grants", glog.size(), 8);
    chk("t4_waiting", rv[0], 1);
    chk("t4_m0_rdy", ary[0], 0);
    chk("t4_m1_rdy", ary[1], 0);
    r_en = 1;
    for (int i = 0; i < 100 && glog.size() < 9; i++) step();
    chk("t4_ninth", glog.size(), 9);
    drain("t4");

    // last beat and AR handshake in the same cycle
    do_reset();
    r_en = 0;
    rq[0].push_back('{32'h0007_0000, 8'd0});
    req_en[0] = 1;
    for (int i = 0; i < 50 && outst != 5'd1; i++) step();
    ar_en = 0;
    rq[1].push_back('{32'h0008_0000, 8'd2});
    req_en[1] = 1;
    for (int i = 0; i < 50 && !s_if.ARVALID; i++) step();
    chk("t5_issue", s_if.ARVALID, 1);
    ar_en = 1;
    r_en = 1;
    step();
    chk("t5_ar_hs", s_if.ARVALID && s_if.ARREADY, 1);
    chk("t5_r_pop", s_if.RVALID && s_if.RREADY && s_if.RLAST, 1);
    chk("t5_outst_pre", outst, 1);
    step();
    chk("t5_outst_post", outst, 1);
    drain("t5");
    chk("t5_m1_beats", nbeat[1], 3);

    // asynchronous reset with three bursts outstanding
    do_reset();
    r_en = 0;
    rq[0].push_back('{32'h0009_0000, 8'd7});
    rq[0].push_back('{32'h0009_1000, 8'd7});
    rq[1].push_back('{32'h000a_0000, 8'd7});
    req_en[0] = 1;
    req_en[1] = 1;
    for (int i = 0; i < 50 && outst != 5'd3; i++) step();
    r_en = 1;
    repeat (3) step();
    chk("t6_outst3", outst, 3);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("t6_outst", outst, 0);
    chk("t6_arvalid", s_if.ARVALID, 0);
    chk("t6_araddr", s_if.ARADDR, 0);
    chk("t6_arlen", s_if.ARLEN, 0);
    chk("t6_m0_rvalid", rvld[0], 0);
    chk("t6_m1_rvalid", rvld[1], 0);
    chk("t6_rready", s_if.RREADY, 0);
    do_reset();
    rq[0].push_back('{32'h000b_0000, 8'd1});
    rq[1].push_back('{32'h000c_0000, 8'd1});
    req_en[0] = 1;
    req_en[1] = 1;
    for (int i = 0; i < 50 && glog.size() < 1; i++) step();
    chk("t6_first_tie", glog[0], 0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
